// File: rtl/slave_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : slave_port                                                 |
// | Description : Serial-bus slave. Takes a serial header (address + burst)  |
// |               and write data, and serialises read data back. Drives a    |
// |               local memory. Optional range check: SLAVE_PORT_RANGE_CHECK_EN|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module slave_port #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 13,
    parameter int MEM_SIZE  = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                master_valid,
    input  logic                master_ready,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rx_address,
    input  logic                rx_burst_num,
    input  logic                rx_data,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                slave_ready,
    output logic                slave_valid,
    output logic                tx_data,
    output logic                slave_tx_done,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    output logic                addr_err
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_header = 3'd1;
    localparam logic [2:0] c_st_wdata  = 3'd2;
    localparam logic [2:0] c_st_wstore = 3'd3;
    localparam logic [2:0] c_st_rfetch = 3'd4;
    localparam logic [2:0] c_st_rwait  = 3'd5;
    localparam logic [2:0] c_st_rsend  = 3'd6;
    localparam logic [2:0] c_st_done   = 3'd7;

    localparam int c_hcw = $clog2(BURST_LEN + 1);
    localparam int c_bcw = $clog2(DATA_LEN + 1);
    localparam logic [c_hcw-1:0]  c_hdr_last  = c_hcw'(BURST_LEN - 1);
    localparam logic [c_hcw-1:0]  c_addr_bits = c_hcw'(ADDR_LEN);
    localparam logic [c_bcw-1:0]  c_bit_last  = c_bcw'(DATA_LEN - 1);
    localparam logic [ADDR_LEN:0] c_mem_size  = (ADDR_LEN + 1)'(MEM_SIZE);
`ifdef SLAVE_PORT_RANGE_CHECK_EN
    localparam logic c_range_en = 1'b1;
`else
    localparam logic c_range_en = 1'b0;
`endif

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [c_hcw-1:0]     r_hdr_cnt;
    logic [c_bcw-1:0]     r_bit_cnt;
    logic                 r_is_write;
    logic [ADDR_LEN-1:0]  r_addr;
    logic [BURST_LEN-1:0] r_burst;
    logic [DATA_LEN-1:0]  r_shift;
    logic                 r_addr_err;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_hdr_acc;
    logic                 w_last_beat;
    logic                 w_oob;

    assign w_accept    = master_valid & slave_ready;
    assign w_start     = (r_state == c_st_idle) & w_accept & (write_en | read_en);
    assign w_hdr_acc   = w_start | ((r_state == c_st_header) & w_accept);
    // Burst counts down in place; a value of 0 or 1 means this is the final beat.
    assign w_last_beat = (r_burst[BURST_LEN-1:1] == '0);
    assign w_oob       = c_range_en & ({1'b0, r_addr} >= c_mem_size);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:   if (w_start) w_next = c_st_header;
            c_st_header: if (w_accept && r_hdr_cnt == c_hdr_last)
                             w_next = r_is_write ? c_st_wdata : c_st_rfetch;
            c_st_wdata:  if (w_accept && r_bit_cnt == c_bit_last) w_next = c_st_wstore;
            c_st_wstore: w_next = w_last_beat ? c_st_done : c_st_wdata;
            c_st_rfetch: w_next = c_st_rwait;
            c_st_rwait:  w_next = c_st_rsend;
            c_st_rsend:  if (master_ready && r_bit_cnt == c_bit_last)
                             w_next = w_last_beat ? c_st_done : c_st_rfetch;
            c_st_done:   w_next = c_st_idle;
            default:     w_next = c_st_idle;
        endcase
    end

    always_comb begin
        slave_ready   = 1'b0;
        slave_valid   = 1'b0;
        tx_data       = 1'b0;
        slave_tx_done = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        if (!reset) begin
            case (r_state)
                c_st_idle, c_st_header, c_st_wdata: slave_ready = 1'b1;
                c_st_wstore: mem_we = ~w_oob;
                c_st_rfetch: mem_re = ~w_oob;
                c_st_rsend: begin
                    slave_valid = 1'b1;
                    tx_data     = r_shift[0];
                end
                c_st_done:   slave_tx_done = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_burst    <= '0;
            r_shift    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_is_write <= write_en;
                r_addr_err <= 1'b0;
            end
            // Header fields arrive LSB first; address takes only its first ADDR_LEN bits.
            if (w_hdr_acc) begin
                r_burst   <= {rx_burst_num, r_burst[BURST_LEN-1:1]};
                if (r_hdr_cnt < c_addr_bits)
                    r_addr <= {rx_address, r_addr[ADDR_LEN-1:1]};
                r_hdr_cnt <= (r_hdr_cnt == c_hdr_last) ? '0 : r_hdr_cnt + 1'b1;
            end
            case (r_state)
                c_st_wdata: if (w_accept) begin
                    r_shift   <= {rx_data, r_shift[DATA_LEN-1:1]};
                    r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
                end
                c_st_wstore: begin
                    r_addr <= r_addr + 1'b1;
                    if (!w_last_beat) r_burst <= r_burst - 1'b1;
                    if (w_oob) r_addr_err <= 1'b1;
                end
                c_st_rfetch: if (w_oob) r_addr_err <= 1'b1;
                c_st_rwait:  r_shift <= w_oob ? '0 : mem_rdata;
                c_st_rsend: if (master_ready) begin
                    r_shift <= {1'b0, r_shift[DATA_LEN-1:1]};
                    if (r_bit_cnt == c_bit_last) begin
                        r_bit_cnt <= '0;
                        r_addr    <= r_addr + 1'b1;
                        if (!w_last_beat) r_burst <= r_burst - 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_shift;
    assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_slave_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_slave_port                                              |
// | Description : Randomised self-checking bench for slave_port against a    |
// |               transaction-level reference model and memory image.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_slave_port;
    localparam int AL = 12;
    localparam int DL = 8;
    localparam int BL = 13;
    localparam int MS = 2048;
`ifdef SLAVE_PORT_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, master_valid, master_ready, write_en, read_en;
    logic          rx_address, rx_burst_num, rx_data;
    logic [DL-1:0] mem_rdata;
    logic          slave_ready, slave_valid, tx_data, slave_tx_done;
    logic [AL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata;
    logic          mem_we, mem_re, addr_err;

    slave_port #(.ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL), .MEM_SIZE(MS)) dut (
        .clk(clk), .reset(reset), .master_valid(master_valid), .master_ready(master_ready),
        .write_en(write_en), .read_en(read_en), .rx_address(rx_address),
        .rx_burst_num(rx_burst_num), .rx_data(rx_data), .mem_rdata(mem_rdata),
        .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
        .slave_tx_done(slave_tx_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory seen by the DUT, and the image the reference model expects.
    logic [DL-1:0] mem     [0:4095];
    logic [DL-1:0] ref_mem [0:4095];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_re ? mem[mem_addr] : 8'($urandom);
    end

    logic [AL-1:0] wr_a_q[$];
    logic [DL-1:0] wr_d_q[$];
    int            wr_c_q[$];
    bit            tx_q[$];
    int            done_cnt;
    int            sv_cycles;
    always @(negedge clk) begin
        if (mem_we) begin
            wr_a_q.push_back(mem_addr);
            wr_d_q.push_back(mem_wdata);
            wr_c_q.push_back(cyc);
        end
        if (slave_valid) begin
            sv_cycles++;
            if (master_ready) tx_q.push_back(tx_data);
        end
        if (slave_tx_done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int last_acc_cyc;
    int last_hdr_c;

    task automatic send_bit(input bit a, input bit b, input bit d, input bit we, input bit re,
                            input bit stall);
        int  tries = 0;
        bit  fin   = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            master_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            write_en = we; read_en = re;
            rx_address = a; rx_burst_num = b; rx_data = d;
            @(negedge clk);
            if (master_valid && slave_ready) begin
                fin = 1'b1;
                last_acc_cyc = cyc;
            end else if (++tries > 200) begin
                check_eq("accept_timeout", slave_ready, 1);
                fin = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int rdy_mode);
        int n    = 0;
        bit ph   = 1'b0;
        bit seen = 1'b0;
        while (!seen) begin
            @(posedge clk); #1;
            master_valid = 1'b0;
            case (rdy_mode)
                0: master_ready = 1'b1;
                1: if (slave_valid) begin master_ready = ph; ph = ~ph; end
                   else begin master_ready = 1'b0; ph = 1'b0; end
                default: master_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (slave_tx_done) seen = 1'b1;
            else if (++n > 2000) begin
                check_eq("done_timeout", slave_tx_done, 1);
                seen = 1'b1;
            end
        end
    endtask

    task automatic run_txn(input bit is_w, input logic [AL-1:0] addr, input logic [BL-1:0] burst,
                           input logic [DL-1:0] d0, input bit stall, input int rdy_mode);
        int            beats = (burst == 0) ? 1 : int'(burst);
        logic [DL-1:0] wd[$];
        logic [BL-1:0] ax;
        logic [AL-1:0] a;
        logic [DL-1:0] got;
        int            exp_nw  = 0;
        bit            exp_err = 1'b0;
        bit            oob;
        wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete(); tx_q.delete();
        done_cnt = 0; sv_cycles = 0;
        ax = BL'(addr);
        for (int k = 0; k < beats; k++) wd.push_back(k == 0 ? d0 : 8'($urandom));
        for (int i = 0; i < BL; i++) send_bit(ax[i], burst[i], 1'b0, is_w, !is_w, stall);
        last_hdr_c = last_acc_cyc;
        if (is_w)
            for (int k = 0; k < beats; k++)
                for (int b = 0; b < DL; b++) send_bit(1'b0, 1'b0, wd[k][b], 1'b1, 1'b0, stall);
        wait_done(is_w ? 0 : rdy_mode);
        repeat (2) @(negedge clk);
        for (int k = 0; k < beats; k++) begin
            a   = addr + AL'(k);
            oob = RANGE && (int'(a) >= MS);
            if (oob) exp_err = 1'b1;
            if (is_w && !oob) begin
                if (exp_nw < wr_a_q.size()) begin
                    check_eq("wr_addr", wr_a_q[exp_nw], a);
                    check_eq("wr_data", wr_d_q[exp_nw], wd[k]);
                end
                ref_mem[a] = wd[k];
                exp_nw++;
            end
            if (!is_w) begin
                got = '0;
                for (int b = 0; b < DL; b++)
                    if (k * DL + b < tx_q.size()) got[b] = tx_q[k * DL + b];
                check_eq("rd_byte", got, oob ? 8'h00 : ref_mem[a]);
            end
        end
        check_eq("wr_count", wr_a_q.size(), exp_nw);
        if (!is_w) check_eq("rd_bits", tx_q.size(), beats * DL);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("addr_err", addr_err, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DL-1:0] v;
        reset = 1'b1; master_valid = 1'b0; master_ready = 1'b0;
        write_en = 1'b0; read_en = 1'b0;
        rx_address = 1'b0; rx_burst_num = 1'b0; rx_data = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", {slave_ready, slave_valid, tx_data, slave_tx_done, mem_we,
                                   mem_re, addr_err, mem_addr, mem_wdata}, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", slave_ready, 1);

        // Bits with neither direction asserted must be ignored.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            master_valid = 1'b1; write_en = 1'b0; read_en = 1'b0;
            rx_address = 1'($urandom); rx_burst_num = 1'($urandom);
            @(negedge clk);
            check_eq("ignore_ready", slave_ready, 1);
        end

        run_txn(1'b1, 12'h010, 13'd1, 8'hA5, 1'b0, 0);
        if (wr_c_q.size() > 0) check_eq("wr_latency", wr_c_q[0] - last_hdr_c, 9);

        mem[12'h020] = 8'h11; mem[12'h021] = 8'h22; mem[12'h022] = 8'h33;
        ref_mem[12'h020] = 8'h11; ref_mem[12'h021] = 8'h22; ref_mem[12'h022] = 8'h33;
        run_txn(1'b0, 12'h020, 13'd3, 8'h00, 1'b0, 0);
        check_eq("rsend_full", sv_cycles, 3 * DL);

        run_txn(1'b1, 12'hFFF, 13'd2, 8'h3C, 1'b0, 0);
        if (wr_c_q.size() > 1) check_eq("beat_spacing", wr_c_q[1] - wr_c_q[0], DL + 1);

        run_txn(1'b0, 12'hFFF, 13'd2, 8'h00, 1'b0, 1);
        check_eq("rsend_toggle", sv_cycles, 2 * 2 * DL);

        run_txn(1'b0, 12'h123, 13'd0, 8'h00, 1'b0, 0);

        // Reset in the middle of a write word.
        wr_a_q.delete();
        for (int i = 0; i < BL; i++)
            send_bit(i < AL ? 1'(12'h050 >> i) : 1'b0, i == 0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) send_bit(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        master_valid = 1'b0; reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_ready", slave_ready, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("rst_mid_outputs", {mem_we, mem_addr, mem_wdata}, 0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            master_valid = 1'b1; write_en = 1'b0; read_en = 1'b0; rx_data = 1'b1;
        end
        @(negedge clk);
        check_eq("rst_idle_ready", slave_ready, 1);
        check_eq("rst_no_write", wr_a_q.size(), 0);

        run_txn(1'b1, 12'h900, 13'd1, 8'h5A, 1'b0, 0);
        run_txn(1'b0, 12'h900, 13'd1, 8'h00, 1'b0, 0);
        run_txn(1'b1, 12'h7FF, 13'd2, 8'hC3, 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            logic [AL-1:0] ra;
            case ($urandom_range(0, 2))
                0:       ra = AL'($urandom);
                1:       ra = 12'hFFF - AL'($urandom_range(0, 2));
                default: ra = 12'h7FE + AL'($urandom_range(0, 3));
            endcase
            run_txn(1'($urandom), ra, BL'($urandom_range(0, 4)), 8'($urandom),
                    1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
